// File: rtl/buf_rd_stream_pkg.sv
// Shared systolic buffer definitions: default RAM geometry and the read-stream
// state encoding used by the buffer read engines.
package buf_rd_stream_pkg;

  localparam int ADR_W_DEF  = 9;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage : buf_rd_stream_pkg

// File: rtl/buf_rd_stream_skid2.sv
// Two-entry skid FIFO that decouples the one-cycle RAM read latency from
// consumer back-pressure; head word and occupancy are visible directly.
module buf_skid2 #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule : buf_skid2

// File: rtl/buf_rd_stream.sv
// Burst reader: walks a contiguous (wrapping) range of the buffer RAM and
// streams the words out with valid/ready flow control through a skid FIFO.
module buf_rd_stream
  import buf_rd_stream_pkg::*;
#(
  parameter int ADR_W  = ADR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADR_W-1:0]  base_adr,
  input  logic [ADR_W-1:0]  len_m1,
  output logic [ADR_W-1:0]  ram_radr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  rd_state_e        state_q;
  logic [ADR_W-1:0] next_adr_q;
  logic [ADR_W-1:0] last_adr_q;
  logic [ADR_W-1:0] remain_q;
  logic             inflight_q;
  logic             done_q;

  logic [1:0]       fifo_count;
  logic             fifo_pop;
  logic             issue;
  logic             last_xfer;

  assign out_valid = (fifo_count != 2'd0);
  assign fifo_pop  = out_valid && out_ready;

  // A word leaving this cycle frees its slot in time for the read issued now,
  // which is what keeps the stream at one word per cycle.
  assign issue = (state_q == RUN) &&
                 (({1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop}) < 3'd2);

  assign ram_radr  = issue ? next_adr_q : last_adr_q;
  assign last_xfer = (state_q == DRAIN) && fifo_pop && (fifo_count == 2'd1) && !inflight_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      next_adr_q <= '0;
      last_adr_q <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      case (state_q)
        IDLE: begin
          if (start) begin
            next_adr_q <= base_adr;
            remain_q   <= len_m1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            last_adr_q <= next_adr_q;
            next_adr_q <= next_adr_q + 1'b1;
            remain_q   <= remain_q - 1'b1;
            if (remain_q == '0) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (last_xfer) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

  buf_skid2 #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inflight_q),
    .push_data_i(ram_rdata),
    .pop_i      (fifo_pop),
    .head_o     (out_data),
    .count_o    (fifo_count)
  );

endmodule : buf_rd_stream
